// File: rtl/float_conv_pkg.sv
// Shared widths, float operand layout and converter FSM states for the
// integer-to-float and float-to-integer stages.
package float_conv_pkg;

  localparam int INT_W   = 8;
  localparam int EXP_W   = 4;
  localparam int SIG_W   = 8;
  localparam int FLOAT_W = 1 + EXP_W + SIG_W;
  localparam int MAG_W   = INT_W - 1;
  localparam int CNT_W   = 3;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;
  } float_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

endpackage

// File: rtl/float_to_int_converter_if.sv
// Operand and result channels of the float-to-integer converter.
// Both channels: a transfer happens on the rising clock edge where valid and
// ready are both high; the producer holds its payload stable while valid is high.
interface float_to_int_converter_if;
  import float_conv_pkg::*;

  float_t           float_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [INT_W-1:0] int_o;
  logic             ovf_o;
  logic             out_valid_o;
  logic             out_ready_i;

  modport master (
    output float_i, in_valid_i, out_ready_i,
    input  in_ready_o, int_o, ovf_o, out_valid_o
  );

  modport slave (
    input  float_i, in_valid_i, out_ready_i,
    output in_ready_o, int_o, ovf_o, out_valid_o
  );
endinterface

// File: rtl/float_to_int_shifter.sv
// Serial right shifter: one logical shift per cycle while the counter is non-zero.
// With FLOAT_TO_INT_ROUND_EN the last bit shifted out is kept as the round bit.
module float_to_int_shifter
  import float_conv_pkg::*;
#(
  parameter int W = SIG_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load,
  input  logic [W-1:0]     load_data,
  input  logic [CNT_W-1:0] load_count,
  output logic [W-1:0]     data,
  output logic             busy,
  output logic             last
`ifdef FLOAT_TO_INT_ROUND_EN
  ,
  output logic             round_bit
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data  <= '0;
      count <= '0;
    end else if (load) begin
      data  <= load_data;
      count <= load_count;
    end else if (count != '0) begin
      data  <= data >> 1;
      count <= count - CNT_ONE;
    end
  end

`ifdef FLOAT_TO_INT_ROUND_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      round_bit <= 1'b0;
    end else if (load) begin
      round_bit <= 1'b0;
    end else if (count != '0) begin
      round_bit <= data[0];
    end
  end
`endif

  assign busy = (count != '0);
  assign last = (count == CNT_ONE);

endmodule

// File: rtl/float_to_int_converter.sv
// Multi-cycle float {sign, exp, sig} to sign-magnitude integer converter.
// Define FLOAT_TO_INT_ROUND_EN for round half-up; otherwise the result is truncated.
module float_to_int_converter
  import float_conv_pkg::*;
#(
  parameter int INT_WIDTH = INT_W,
  parameter int EXP_WIDTH = EXP_W,
  parameter int SIG_WIDTH = SIG_W
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  float_to_int_converter_if.slave     bus,
  output conv_state_e                 dbg_state
);

  localparam int MAG_WIDTH = INT_WIDTH - 1;

  conv_state_e state, state_next;

  logic                 sign_in;
  logic [EXP_WIDTH-1:0] exp_in;
  logic [SIG_WIDTH-1:0] sig_in;
  logic                 accept;
  logic                 is_zero;
  logic                 is_sat;
  logic                 shift_load;
  logic [CNT_W-1:0]     shift_count;

  logic                 sign_q;
  logic                 from_shift_q;
  logic                 sat_q;

  logic [SIG_WIDTH-1:0] sh_data;
  logic                 sh_busy;
  logic                 sh_last;
`ifdef FLOAT_TO_INT_ROUND_EN
  logic                 sh_round;
`endif

  logic [SIG_WIDTH-1:0] rounded;
  logic [MAG_WIDTH-1:0] mag;
  logic                 ovf;

  assign sign_in     = bus.float_i.sign;
  assign exp_in      = bus.float_i.exp;
  assign sig_in      = bus.float_i.sig;
  assign accept      = (state == IDLE) && bus.in_valid_i;
  assign is_zero     = (exp_in == '0) || (sig_in == '0);
  assign is_sat      = !is_zero && (int'(exp_in) >= SIG_WIDTH);
  assign shift_load  = accept && !is_zero && !is_sat;
  // exp is 1..7 here, so the shift distance always fits the counter.
  assign shift_count = CNT_W'(SIG_WIDTH - int'(exp_in));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.in_valid_i) state_next = shift_load ? SHIFT : DONE;
      SHIFT:   if (sh_last || !sh_busy) state_next = DONE;
      DONE:    if (bus.out_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready_o  = (state == IDLE);
    bus.out_valid_o = (state == DONE);
    dbg_state       = state;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sign_q       <= 1'b0;
      from_shift_q <= 1'b0;
      sat_q        <= 1'b0;
    end else if (accept) begin
      sign_q       <= sign_in;
      from_shift_q <= shift_load;
      sat_q        <= is_sat;
    end
  end

  float_to_int_shifter #(
    .W (SIG_WIDTH)
  ) u_shifter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load       (shift_load),
    .load_data  (sig_in),
    .load_count (shift_count),
    .data       (sh_data),
    .busy       (sh_busy),
    .last       (sh_last)
`ifdef FLOAT_TO_INT_ROUND_EN
    ,
    .round_bit  (sh_round)
`endif
  );

  // After at least one shift the top bit is clear, so a set top bit can only
  // come from rounding 127 up to 128.
  always_comb begin
    rounded = sh_data;
`ifdef FLOAT_TO_INT_ROUND_EN
    rounded = sh_data + {{(SIG_WIDTH-1){1'b0}}, sh_round};
`endif
    mag = '0;
    ovf = 1'b0;
    if (from_shift_q) begin
      ovf = rounded[SIG_WIDTH-1];
      mag = ovf ? '1 : rounded[MAG_WIDTH-1:0];
    end else if (sat_q) begin
      ovf = 1'b1;
      mag = '1;
    end
    bus.int_o = {sign_q && (mag != '0), mag};
    bus.ovf_o = ovf;
  end

endmodule
